// File: rtl/alu_seq_acc.sv
// ---------------------------------------------------------------------------
// alu_seq_acc
//   Sequential ALU with an accumulator-style result register. Operands A and
//   B combine under a 3-bit opcode into a registered 2W-bit result. Most ops
//   complete in one cycle. MUL is a multi-cycle shift-add that takes W steps.
//   The low half of the result can replace the external B operand, so
//   operations can be chained without re-entering operands.
//
// Ports
//   clk      in   1    rising-edge clock for all state
//   resetn   in   1    synchronous active-low reset
//   a        in   W    operand A
//   b        in   W    external operand B
//   use_acc  in   1    1: B comes from result[W-1:0], 0: B comes from b
//   op       in   3    opcode, sampled together with start
//   start    in   1    request, accepted only while idle
//   busy     out  1    high while a multiply is in progress
//   done     out  1    one-cycle pulse after result has been updated
//   result   out  2W   registered ALU result
// ---------------------------------------------------------------------------
module alu_seq_acc #(
  parameter int W     = 4,
  parameter int CNT_W = 3
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           use_acc,
  input  logic [2:0]     op,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result
);

  localparam int RW = 2 * W;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LOG  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_RAND = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  // The final multiply step is the one where the counter reaches W-1.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [W-1:0]    b_sel;
  logic [RW-1:0]   alu_val;
  logic            accept;
  logic            last_step;

  // The multiplicand shifts left and the multiplier shifts right once per
  // step, so each step only needs the multiplier LSB and no variable shifter.
  logic [RW-1:0]   mul_a;
  logic [W-1:0]    mul_b;
  logic [RW-1:0]   prod;
  logic [RW-1:0]   prod_next;
  logic [CNT_W-1:0] count;

  // Operand B selection and single-cycle ALU functions. The accumulator path
  // reads result as it stands before the accepting edge.
  always_comb begin
    b_sel   = use_acc ? result[W-1:0] : b;
    alu_val = result;
    case (op)
      OP_ADD:  alu_val = RW'({1'b0, a} + {1'b0, b_sel});
      OP_SUB:  alu_val = RW'(a) - RW'(b_sel);
      OP_LOG:  alu_val = {a | b_sel, a ^ b_sel};
      OP_ROR:  alu_val = RW'(|{a, b_sel});
      OP_RAND: alu_val = RW'(&{a, b_sel});
      OP_SWAP: alu_val = {b_sel, a};
      default: alu_val = result;
    endcase
  end

  // One shift-add step of the multiplier.
  always_comb begin
    prod_next = prod + (mul_b[0] ? mul_a : '0);
    last_step = (count == LAST_STEP);
  end

  // Next-state logic. A start is only ever accepted from IDLE, which is what
  // makes start-while-busy harmless.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start && (op == OP_MUL)) begin
          state_next = MUL;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath. done defaults low every cycle so it can only ever be a single
  // pulse per completed request; reset clears the multiplier so an aborted
  // multiply can never write result later.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result <= '0;
      done   <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
      prod   <= '0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (op == OP_MUL) begin
            mul_a <= RW'(a);
            mul_b <= b_sel;
            prod  <= '0;
            count <= '0;
          end else begin
            result <= alu_val;
            done   <= 1'b1;
          end
        end
      end else begin
        prod  <= prod_next;
        mul_a <= mul_a << 1;
        mul_b <= mul_b >> 1;
        count <= count + 1'b1;
        if (last_step) begin
          result <= prod_next;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_acc.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_acc
//   Directed self-checking bench for alu_seq_acc with W=4. Each task drives
//   one scenario and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_seq_acc;

  localparam int W = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LOG  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_RAND = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_HOLD = 3'b111;

  logic           clk;
  logic           resetn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           use_acc;
  logic [2:0]     op;
  logic           start;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  int n_checks;
  int n_fail;

  alu_seq_acc #(.W(W), .CNT_W(3)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .a       (a),
    .b       (b),
    .use_acc (use_acc),
    .op      (op),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one accepting edge, then drop start.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic acc);
    op      = o;
    a       = va;
    b       = vb;
    use_acc = acc;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b1;
    op     = OP_ADD;
    a      = 4'h7;
    b      = 4'h7;
    tick();
    tick();
    start = 1'b0;
    n_checks++;
    if (result !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_result: got %h expected 00", result);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_add();
    issue(OP_ADD, 4'h5, 4'h3, 1'b0);
    n_checks++;
    if (result !== 8'h08 || done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL add_5_3: got %h done=%b expected 08 done=1", result, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || result !== 8'h08) begin
      n_fail++;
      $display("[TB] FAIL add_done_pulse: got done=%b result=%h expected 0 08", done, result);
    end
    issue(OP_ADD, 4'hF, 4'hF, 1'b0);
    n_checks++;
    if (result !== 8'h1E) begin
      n_fail++;
      $display("[TB] FAIL add_f_f: got %h expected 1e", result);
    end
    tick();
  endtask

  task automatic test_ops();
    logic [2:0]   ops [6];
    logic [W-1:0] va  [6];
    logic [W-1:0] vb  [6];
    logic [7:0]   exp [6];
    ops = '{OP_SUB, OP_LOG, OP_SWAP, OP_ROR, OP_RAND, OP_HOLD};
    va  = '{4'h3, 4'hA, 4'h1, 4'h0, 4'hF, 4'h9};
    vb  = '{4'h5, 4'h6, 4'h2, 4'h0, 4'hF, 4'h9};
    exp = '{8'hFE, 8'hEC, 8'h21, 8'h00, 8'h01, 8'h01};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], va[i], vb[i], 1'b0);
      n_checks++;
      if (result !== exp[i] || done !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL op_%0d: got %h done=%b expected %h done=1", ops[i], result, done, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_mul();
    issue(OP_MUL, 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < W; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || result !== 8'h01) begin
        n_fail++;
        $display("[TB] FAIL mul_busy_%0d: got busy=%b done=%b result=%h expected 1 0 01", i, busy, done, result);
      end
      // A stray request and operand changes mid-multiply must be ignored.
      if (i == 1) begin
        start = 1'b1;
        op    = OP_ADD;
        a     = 4'h1;
        b     = 4'h1;
      end else begin
        start = 1'b0;
        a     = 4'h0;
      end
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (result !== 8'hE1 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mul_f_f: got %h done=%b busy=%b expected e1 1 0", result, done, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || result !== 8'hE1) begin
      n_fail++;
      $display("[TB] FAIL mul_after: got done=%b result=%h expected 0 e1", done, result);
    end
  endtask

  task automatic test_chain();
    issue(OP_ADD, 4'h2, 4'h3, 1'b0);
    n_checks++;
    if (result !== 8'h05 || done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL chain_add: got %h done=%b expected 05 1", result, done);
    end
    // Request on the done cycle; b is junk because B comes from the accumulator.
    issue(OP_MUL, 4'h3, 4'h9, 1'b1);
    use_acc = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL chain_accept: got busy=%b expected 1", busy);
    end
    for (int i = 0; i < W; i++) tick();
    n_checks++;
    if (result !== 8'h0F || done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL chain_mul: got %h done=%b expected 0f 1", result, done);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    issue(OP_MUL, 4'hF, 4'hF, 1'b0);
    tick();
    resetn = 1'b0;
    tick();
    n_checks++;
    if (result !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_mul_reset: got %h busy=%b done=%b expected 00 0 0", result, busy, done);
    end
    resetn = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL late_done_%0d: got done=%b busy=%b result=%h expected 0 0 00", i, done, busy, result);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ops [5];
    logic [W-1:0] va  [5];
    logic [W-1:0] vb  [5];
    logic         acc [5];
    logic [7:0]   exp [5];
    ops = '{OP_ADD, OP_SUB, OP_SWAP, OP_LOG, OP_ADD};
    va  = '{4'h1, 4'h7, 4'h3, 4'h5, 4'h1};
    vb  = '{4'h1, 4'h2, 4'h4, 4'h3, 4'hF};
    acc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp = '{8'h02, 8'h05, 8'h43, 8'h76, 8'h07};
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op      = ops[i];
      a       = va[i];
      b       = vb[i];
      use_acc = acc[i];
      tick();
      n_checks++;
      if (result !== exp[i] || done !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL b2b_%0d: got %h done=%b expected %h 1", i, result, done, exp[i]);
      end
    end
    start   = 1'b0;
    use_acc = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || result !== 8'h07) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle: got done=%b result=%h expected 0 07", done, result);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    use_acc  = 1'b0;
    op       = OP_ADD;
    a        = '0;
    b        = '0;
    test_reset();
    test_add();
    test_ops();
    test_mul();
    test_chain();
    test_reset_mid_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
